// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the Mem-stage access controller.
// Holds the access-size encoding, the controller states and the byte-lane helpers.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    MSize_zero  = 3'd0,
    MSize_byte  = 3'd1,
    MSize_half  = 3'd2,
    MSize_word  = 3'd3,
    MSize_dword = 3'd4
  } MemSizeType;

  typedef logic [1:0] mem_state_t;

  localparam mem_state_t IDLE = 2'd0;
  localparam mem_state_t BUSY = 2'd1;
  localparam mem_state_t DONE = 2'd2;

  localparam logic [7:0] MASK_BYTE  = 8'h01;
  localparam logic [7:0] MASK_HALF  = 8'h03;
  localparam logic [7:0] MASK_WORD  = 8'h0F;
  localparam logic [7:0] MASK_DWORD = 8'hFF;

  function automatic logic [7:0] size_mask(input logic [2:0] size);
    case (size)
      MSize_byte:  size_mask = MASK_BYTE;
      MSize_half:  size_mask = MASK_HALF;
      MSize_word:  size_mask = MASK_WORD;
      MSize_dword: size_mask = MASK_DWORD;
      default:     size_mask = 8'h00;
    endcase
  endfunction

  // An access is aligned when the low address bits covered by its size are zero.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] off);
    case (size)
      MSize_half:  is_misaligned = off[0];
      MSize_word:  is_misaligned = |off[1:0];
      MSize_dword: is_misaligned = |off;
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_data_align.sv
// mem_data_align: combinational byte-lane steering for the data bus.
// Places store data/strobes on their lanes and extracts/extends load data.
module mem_data_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [2:0]  off,
  input  logic        write,
  input  logic        load_unsigned,
  input  logic [63:0] store_data,
  input  logic [63:0] bus_rdata,
  output logic [7:0]  strobe,
  output logic [63:0] lane_wdata,
  output logic [63:0] load_data
);

  logic [63:0] shifted;

  assign shifted    = bus_rdata >> {off, 3'b000};
  assign lane_wdata = store_data << {off, 3'b000};
  // Mask bits pushed past lane 7 fall off the 8-bit result.
  assign strobe     = write ? (size_mask(size) << off) : 8'h00;

  always_comb begin
    load_data = shifted;
    case (size)
      MSize_byte:
        load_data = load_unsigned ? {56'b0, shifted[7:0]}
                                  : {{56{shifted[7]}}, shifted[7:0]};
      MSize_half:
        load_data = load_unsigned ? {48'b0, shifted[15:0]}
                                  : {{48{shifted[15]}}, shifted[15:0]};
      MSize_word:
        load_data = load_unsigned ? {32'b0, shifted[31:0]}
                                  : {{32{shifted[31]}}, shifted[31:0]};
      default:
        load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences Mem-stage loads/stores onto the data bus and stalls until done.
// Optional MEM_MISALIGN_CHECK_EN: misaligned accesses skip the bus and flag misalign.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        misalign,
  output logic        dbus_valid,
  output logic [63:0] dbus_addr,
  output logic [2:0]  dbus_size,
  output logic [7:0]  dbus_strobe,
  output logic [63:0] dbus_wdata,
  input  logic        dbus_data_ok,
  input  logic [63:0] dbus_rdata
);

  mem_state_t  state;
  logic [63:0] addr_q;
  logic [2:0]  size_q;
  logic        unsigned_q;
  logic        write_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        mem_req;
  logic [7:0]  lane_strobe;
  logic [63:0] load_data;
  logic        unused_funct3;

  assign unused_funct3 = &req_funct3[1:0];

  assign mem_req     = req_valid & (req_read | req_write);
  assign stall       = mem_req & (state != DONE);
  assign done        = (state == DONE);
  assign dbus_valid  = (state == BUSY);
  assign dbus_addr   = addr_q;
  assign dbus_size   = size_q;
  assign dbus_strobe = lane_strobe & {8{dbus_valid}};
  assign rdata       = rdata_q;

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  mem_data_align u_align (
    .size          (size_q),
    .off           (addr_q[2:0]),
    .write         (write_q),
    .load_unsigned (unsigned_q),
    .store_data    (wdata_q),
    .bus_rdata     (dbus_rdata),
    .strobe        (lane_strobe),
    .lane_wdata    (dbus_wdata),
    .load_data     (load_data)
  );

  // Request registers keep the bus fields stable for the whole transaction;
  // a read+write request is demoted to a plain read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= MSize_zero;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            unsigned_q <= req_funct3[2];
            write_q    <= req_write & ~req_read;
            wdata_q    <= req_wdata;
            state      <= BUSY;
`ifdef MEM_MISALIGN_CHECK_EN
            if (is_misaligned(req_size, req_addr[2:0])) begin
              state      <= DONE;
              rdata_q    <= '0;
              misalign_q <= 1'b1;
            end
`endif
          end
        end
        BUSY: begin
          if (dbus_data_ok) begin
            rdata_q <= load_data;
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
`ifdef MEM_MISALIGN_CHECK_EN
          misalign_q <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
